// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master side issues operands and the slave side returns the held result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B,
    input  Diff, Borrow, busy, done
  );

  modport slave (
    input  start, A, B,
    output Diff, Borrow, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor slice plus a registered borrow.
// The result is assembled in a shadow register, so Diff only changes on completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             bf;
  logic [CW-1:0]    cnt;

  function automatic logic fs_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  // Bit d enters at the MSB; written without a part-select so WIDTH=1 is legal.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic d);
    logic [WIDTH-1:0] t;
    t = r >> 1;
    t[WIDTH-1] = d;
    return t;
  endfunction

  logic             d;
  logic             bnext;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    d        = fs_diff(sa[0], sb[0], bf);
    bnext    = fs_borrow(sa[0], sb[0], bf);
    res_next = shift_in(res, d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      bf         <= 1'b0;
      cnt        <= '0;
      bus.Diff   <= '0;
      bus.Borrow <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa       <= bus.A;
            sb       <= bus.B;
            bf       <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_next;
          bf  <= bnext;
          cnt <= cnt + CW'(1);
          // Last bit: publish the full result together with the final borrow.
          if (cnt == CW'(WIDTH - 1)) begin
            bus.Diff   <= res_next;
            bus.Borrow <= bnext;
            bus.done   <= 1'b1;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a WIDTH=8 and a WIDTH=1 instance
// share clock and reset; expected {Borrow,Diff} are queued at launch, popped on done.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) i8 ();
  serial_subtractor_if #(.WIDTH(1)) i1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(i8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

  int total = 0;
  int bad   = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumers: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && i8.done) begin
      if (q8.size() == 0) chk("spurious_done8", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("diff8", 32'(i8.Diff), 32'(e8[7:0]));
        chk("borrow8", 32'(i8.Borrow), 32'(e8[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && i1.done) begin
      if (q1.size() == 0) chk("spurious_done1", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("diff1", 32'(i1.Diff), 32'(e1[0]));
        chk("borrow1", 32'(i1.Borrow), 32'(e1[1]));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge E0.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b};
    i8.A = a;
    i8.B = b;
    i8.start = 1'b1;
    q8.push_back(t);
    @(negedge clk);
    i8.start = 1'b0;
  endtask

  task automatic wait8(input int exp_cycles, input string tag);
    int n = 0;
    while (!i8.done && n < 40) begin
      chk({tag, "_busy"}, 32'(i8.busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_busy_at_done"}, 32'(i8.busy), 32'd0);
  endtask

  logic [7:0] ta [4] = '{8'h03, 8'h00, 8'hFF, 8'h00};
  logic [7:0] tb [4] = '{8'h05, 8'hFF, 8'h01, 8'h00};

  initial begin
    rst = 1'b1;
    i8.start = 1'b0; i8.A = '0; i8.B = '0;
    i1.start = 1'b0; i1.A = '0; i1.B = '0;
    #1;
    chk("rst_diff", 32'(i8.Diff), 32'd0);
    chk("rst_borrow", 32'(i8.Borrow), 32'd0);
    chk("rst_busy", 32'(i8.busy), 32'd0);
    chk("rst_done", 32'(i8.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic 5 - 3, then single-cycle done pulse.
    @(negedge clk);
    launch8(8'h05, 8'h03);
    wait8(8, "basic");
    @(negedge clk);
    chk("done_pulse", 32'(i8.done), 32'd0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      launch8(ta[i], tb[i]);
      wait8(8, "table");
    end

    // Start during RUN (cycle 3) with new operands must be ignored.
    @(negedge clk);
    launch8(8'h10, 8'h01);
    repeat (2) @(negedge clk);
    i8.A = 8'hAA; i8.B = 8'h55; i8.start = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    wait8(5, "ignored");
    @(negedge clk);
    chk("ignored_done_pulse", 32'(i8.done), 32'd0);

    // Back-to-back: second start issued in the done cycle.
    @(negedge clk);
    launch8(8'h22, 8'h11);
    wait8(8, "b2b_first");
    launch8(8'h80, 8'h01);
    wait8(8, "b2b_second");
    @(negedge clk);
    chk("b2b_done_pulse", 32'(i8.done), 32'd0);

    // Asynchronous reset between edges in RUN cycle 4.
    @(negedge clk);
    launch8(8'h40, 8'h01);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_diff", 32'(i8.Diff), 32'd0);
    chk("arst_borrow", 32'(i8.Borrow), 32'd0);
    chk("arst_busy", 32'(i8.busy), 32'd0);
    chk("arst_done", 32'(i8.done), 32'd0);
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(i8.busy), 32'd0);
    launch8(8'h09, 8'h04);
    wait8(8, "post_rst");

    // WIDTH=1 instance: half-subtractor truth table, done one edge after E0.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] t1;
      logic       a1;
      logic       b1;
      a1 = i[1];
      b1 = i[0];
      t1 = {1'b0, a1} - {1'b0, b1};
      @(negedge clk);
      i1.A = a1; i1.B = b1; i1.start = 1'b1;
      q1.push_back(t1);
      @(negedge clk);
      i1.start = 1'b0;
      chk("w1_busy", 32'(i1.busy), 32'd1);
      chk("w1_done_early", 32'(i1.done), 32'd0);
      @(negedge clk);
      chk("w1_done", 32'(i1.done), 32'd1);
      chk("w1_busy_idle", 32'(i1.busy), 32'd0);
    end

    @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor that computes Diff = A - B, LSB first, one bit per clock.
- It is the inverse counterpart of the team's adder cells and is built from a single full-subtractor slice plus a registered borrow.
- Sits beside the adder blocks as the area-cheap subtract path for multi-cycle datapaths.
- Uses a start/busy/done handshake with operand capture and a held result.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1 to 32).

Ports:
clk  input  1  single clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only when idle
A  input  WIDTH  minuend, captured on accepted start
B  input  WIDTH  subtrahend, captured on accepted start
Diff  output  WIDTH  registered result (A - B) mod 2^WIDTH
Borrow  output  1  registered final borrow-out (1 when A < B unsigned)
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse when Diff/Borrow update

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - state=IDLE; Diff=0, Borrow=0, busy=0, done=0.
  - Internal shift registers, bit counter and borrow flop all cleared.
  - Takes effect immediately, independent of clk.
- FSM has two states, IDLE and RUN.
- IDLE behaviour:
  - busy=0.
  - On a rising edge with start=1: capture A into sa and B into sb; clear borrow flop bf; counter cnt=0; go to RUN.
  - start=0: remain in IDLE; outputs hold.
- RUN behaviour, per edge:
  - d = sa[0] ^ sb[0] ^ bf.
  - bnext = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bf).
  - sa and sb shift right by one; d shifts into the MSB of an internal result shift register; bf <= bnext; cnt <= cnt+1.
  - Counter width is clog2(WIDTH+1); no wrap occurs within one operation.
- Completion:
  - On the edge that processes bit WIDTH-1 (cnt == WIDTH-1), Diff takes the full shifted result and Borrow <= bnext.
  - Same edge: done <= 1 and state returns to IDLE.
  - done deasserts on the following edge unless another completion occurs.
- Latency:
  - Start sampled at edge E0; busy=1 after E0.
  - Result, done=1 and busy=0 all appear after edge E_WIDTH.
  - Throughput is one operation per WIDTH+1 cycles maximum.
- Diff/Borrow hold the last completed result until the next completion; intermediate bits are never visible on Diff.
- start while busy=1 is ignored, with no queuing; A/B changes during RUN have no effect.
- start=1 in the cycle done=1 (state is IDLE) is accepted: back-to-back operation, and done falls on the next edge.
- Reset asserted mid-RUN:
  - Operation aborts, no done pulse, Diff/Borrow return to 0.
  - After release the block is in IDLE.
- WIDTH=1: RUN lasts one edge; result equals the half-subtractor truth table.
- Arithmetic is unsigned modulo 2^WIDTH; Borrow=1 exactly when A < B.

Test Plan:
- WIDTH=8, A=0x05, B=0x03, start one cycle -> busy high 8 cycles; after E8 Diff=0x02, Borrow=0, done pulses exactly one cycle.
- A=0x03, B=0x05 -> Diff=0xFE, Borrow=1. A=0x00, B=0xFF -> Diff=0x01, Borrow=1. A=0xFF, B=0x01 -> Diff=0xFE, Borrow=0. A=B=0x00 -> Diff=0x00, Borrow=0.
- Start with A=0x10, B=0x01; at cycle 3 of RUN, pulse start with A=0xAA, B=0x55 -> ignored; result Diff=0x0F, Borrow=0 at E8; no second done.
- Assert start in the done cycle with A=0x80, B=0x01 -> accepted, busy stays effectively continuous, and second done 8 cycles later with Diff=0x7F, Borrow=0.
- Assert rst asynchronously (between clock edges) at RUN cycle 4 -> Diff=0, Borrow=0, busy=0, done=0 immediately; no done after release. Then a new start with A=0x09, B=0x04 -> Diff=0x05.
- WIDTH=1 instance, all four (A,B) pairs -> (Diff,Borrow) = (0,0),(1,1),(1,0),(0,0) for (0,0),(0,1),(1,0),(1,1); done one edge after start.
